// File: rtl/gemm_loop_ctrl_pkg.sv
// GEMM loop sequencer shared definitions: instruction/uop field layout,
// FSM encoding and the beat bundle carried through the holding buffer.
package gemm_loop_ctrl_pkg;

    localparam int INSN_W = 128;
    localparam int UOP_W  = 32;
    localparam int IDX_W  = 14;

    localparam int RST_BIT = 7;
    localparam int BGN_LSB = 8;
    localparam int BGN_MSB = 20;
    localparam int END_LSB = 21;
    localparam int END_MSB = 34;
    localparam int IO_LSB  = 35;
    localparam int IO_MSB  = 48;
    localparam int II_LSB  = 49;
    localparam int II_MSB  = 62;
    localparam int DFO_LSB = 63;
    localparam int DFO_MSB = 73;
    localparam int DFI_LSB = 74;
    localparam int DFI_MSB = 84;
    localparam int SFO_LSB = 85;
    localparam int SFO_MSB = 95;
    localparam int SFI_LSB = 96;
    localparam int SFI_MSB = 106;
    localparam int WFO_LSB = 107;
    localparam int WFO_MSB = 116;
    localparam int WFI_LSB = 117;
    localparam int WFI_MSB = 126;

    localparam int UOP_ACC_LSB = 0;
    localparam int UOP_ACC_MSB = 10;
    localparam int UOP_INP_LSB = 11;
    localparam int UOP_INP_MSB = 21;
    localparam int UOP_WGT_LSB = 22;
    localparam int UOP_WGT_MSB = 31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              reset_reg;
        logic [12:0]       uop_bgn;
        logic [IDX_W-1:0]  uop_end;
        logic [IDX_W-1:0]  iter_out;
        logic [IDX_W-1:0]  iter_in;
        logic [10:0]       dst_out;
        logic [10:0]       dst_in;
        logic [10:0]       src_out;
        logic [10:0]       src_in;
        logic [9:0]        wgt_out;
        logic [9:0]        wgt_in;
    } insn_t;

    typedef struct packed {
        logic [UOP_W-1:0] uop;
        logic [IDX_W-1:0] iter_out;
        logic [IDX_W-1:0] iter_in;
        logic             last;
    } beat_t;

    function automatic insn_t decode_insn(input logic [INSN_W-1:0] w);
        insn_t f;
        f.reset_reg = w[RST_BIT];
        f.uop_bgn   = w[BGN_MSB:BGN_LSB];
        f.uop_end   = w[END_MSB:END_LSB];
        f.iter_out  = w[IO_MSB:IO_LSB];
        f.iter_in   = w[II_MSB:II_LSB];
        f.dst_out   = w[DFO_MSB:DFO_LSB];
        f.dst_in    = w[DFI_MSB:DFI_LSB];
        f.src_out   = w[SFO_MSB:SFO_LSB];
        f.src_in    = w[SFI_MSB:SFI_LSB];
        f.wgt_out   = w[WFO_MSB:WFO_LSB];
        f.wgt_in    = w[WFI_MSB:WFI_LSB];
        return f;
    endfunction

    function automatic logic zero_trip(input insn_t f);
        return (f.iter_out == '0) || (f.iter_in == '0) ||
               (f.uop_end <= {1'b0, f.uop_bgn});
    endfunction

endpackage

// File: rtl/gemm_loop_skid.sv
// Two-entry order-preserving holding buffer; an empty buffer passes the
// returning SRAM beat straight through so data is presented the cycle it lands.
module gemm_loop_skid
    import gemm_loop_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    input  beat_t      in_beat_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output beat_t      out_beat_o,
    output logic [1:0] occ_o
);

    logic [1:0] cnt_q, cnt_d;
    beat_t      e0_q, e0_d;
    beat_t      e1_q, e1_d;
    logic       pop;

    assign out_valid_o = (cnt_q != 2'd0) || in_valid_i;
    assign pop         = out_valid_o && out_ready_i;
    assign occ_o       = cnt_q;

    always_comb begin
        out_beat_o = '0;
        if (cnt_q != 2'd0) begin
            out_beat_o = e0_q;
        end else if (in_valid_i) begin
            out_beat_o = in_beat_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        unique case (cnt_q)
            2'd0: begin
                if (in_valid_i && !pop) begin
                    e0_d  = in_beat_i;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop) begin
                    if (in_valid_i) begin
                        e0_d = in_beat_i;
                    end else begin
                        cnt_d = 2'd0;
                    end
                end else if (in_valid_i) begin
                    e1_d  = in_beat_i;
                    cnt_d = 2'd2;
                end
            end
            2'd2: begin
                // Issue throttling upstream guarantees no arrival while full and stalled.
                if (pop) begin
                    e0_d = e1_q;
                    if (in_valid_i) begin
                        e1_d = in_beat_i;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/gemm_loop_ctrl.sv
// GEMM loop sequencer: walks iter_out x iter_in x uop range, fetching
// each micro-op from SRAM and emitting one indexed beat per fetch.
module gemm_loop_ctrl
    import gemm_loop_ctrl_pkg::*;
#(
    parameter int UOP_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              insn_valid,
    output logic              insn_ready,
    input  logic [INSN_W-1:0] insn,
    output logic              uop_rd_en,
    output logic [UOP_AW-1:0] uop_rd_addr,
    input  logic [UOP_W-1:0]  uop_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [UOP_W-1:0]  out_uop,
    output logic [IDX_W-1:0]  out_iter_out,
    output logic [IDX_W-1:0]  out_iter_in,
    output logic [21:0]       out_dst_factor,
    output logic [21:0]       out_src_factor,
    output logic [19:0]       out_wgt_factor,
    output logic              out_reset,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    insn_t            fld_q, fld_d;
    logic [IDX_W-1:0] u_q, u_d;
    logic [IDX_W-1:0] io_q, io_d;
    logic [IDX_W-1:0] ii_q, ii_d;
    logic             rem_q, rem_d;
    logic             pend_q;
    logic [IDX_W-1:0] pend_io_q, pend_io_d;
    logic [IDX_W-1:0] pend_ii_q, pend_ii_d;
    logic             pend_last_q, pend_last_d;

    insn_t            dec;
    beat_t            in_beat;
    beat_t            head;
    logic [1:0]       buf_occ;
    logic [2:0]       occ_adj;
    logic             pop;
    logic             issue;
    logic             wrap_u, wrap_in, wrap_out;
    logic             unused_dep;

    assign dec        = decode_insn(insn);
    assign unused_dep = ^{insn[INSN_W-1], insn[RST_BIT-1:0]};

    assign in_beat = '{uop: uop_rd_data, iter_out: pend_io_q,
                       iter_in: pend_ii_q, last: pend_last_q};

    gemm_loop_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (pend_q),
        .in_beat_i  (in_beat),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_beat_o (head),
        .occ_o      (buf_occ)
    );

    assign pop      = out_valid && out_ready;
    // Slots committed next cycle: buffered + in flight, less this cycle's drain.
    assign occ_adj  = {1'b0, buf_occ} + {2'b0, pend_q} - {2'b0, pop};
    assign issue    = (state_q == ST_RUN) && rem_q && (occ_adj < 3'd2);

    assign wrap_u   = (u_q + 14'd1) == fld_q.uop_end;
    assign wrap_in  = (ii_q + 14'd1) == fld_q.iter_in;
    assign wrap_out = (io_q + 14'd1) == fld_q.iter_out;

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        fld_d       = fld_q;
        u_d         = u_q;
        io_d        = io_q;
        ii_d        = ii_q;
        rem_d       = rem_q;
        pend_io_d   = pend_io_q;
        pend_ii_d   = pend_ii_q;
        pend_last_d = pend_last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (insn_valid) begin
                    fld_d = dec;
                    u_d   = {1'b0, dec.uop_bgn};
                    io_d  = '0;
                    ii_d  = '0;
                    if (zero_trip(dec)) begin
                        done_d = 1'b1;
                        rem_d  = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    pend_io_d   = io_q;
                    pend_ii_d   = ii_q;
                    pend_last_d = wrap_u && wrap_in && wrap_out;
                    if (!wrap_u) begin
                        u_d = u_q + 14'd1;
                    end else begin
                        u_d = {1'b0, fld_q.uop_bgn};
                        if (!wrap_in) begin
                            ii_d = ii_q + 14'd1;
                        end else begin
                            ii_d = '0;
                            if (!wrap_out) begin
                                io_d = io_q + 14'd1;
                            end else begin
                                rem_d = 1'b0;
                            end
                        end
                    end
                end
                if (pop && head.last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            fld_q       <= '0;
            u_q         <= '0;
            io_q        <= '0;
            ii_q        <= '0;
            rem_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_io_q   <= '0;
            pend_ii_q   <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            fld_q       <= fld_d;
            u_q         <= u_d;
            io_q        <= io_d;
            ii_q        <= ii_d;
            rem_q       <= rem_d;
            pend_q      <= issue;
            pend_io_q   <= pend_io_d;
            pend_ii_q   <= pend_ii_d;
            pend_last_q <= pend_last_d;
        end
    end

    assign insn_ready     = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign uop_rd_en      = issue;
    assign uop_rd_addr    = u_q[UOP_AW-1:0];
    assign out_uop        = head.uop;
    assign out_iter_out   = head.iter_out;
    assign out_iter_in    = head.iter_in;
    assign out_last       = head.last;
    assign out_reset      = fld_q.reset_reg;
    assign out_dst_factor = {fld_q.dst_in, fld_q.dst_out};
    assign out_src_factor = {fld_q.src_in, fld_q.src_out};
    assign out_wgt_factor = {fld_q.wgt_in, fld_q.wgt_out};

endmodule

// File: tb/tb_gemm_loop_ctrl.sv
// Bench for gemm_loop_ctrl: SRAM model, loop-nest reference queue,
// randomized back-pressure and instructions, mid-run reset.
module tb_gemm_loop_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         insn_valid;
    logic         insn_ready;
    logic [127:0] insn;
    logic         uop_rd_en;
    logic [12:0]  uop_rd_addr;
    logic [31:0]  uop_rd_data = '0;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_uop;
    logic [13:0]  out_iter_out;
    logic [13:0]  out_iter_in;
    logic [21:0]  out_dst_factor;
    logic [21:0]  out_src_factor;
    logic [19:0]  out_wgt_factor;
    logic         out_reset;
    logic         out_last;
    logic         busy;
    logic         done;

    logic [31:0]  mem [0:8191];
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (uop_rd_en) uop_rd_data <= mem[uop_rd_addr];

    gemm_loop_ctrl #(.UOP_AW(13)) dut (
        .clk(clk), .rst(rst),
        .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn),
        .uop_rd_en(uop_rd_en), .uop_rd_addr(uop_rd_addr),
        .uop_rd_data(uop_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uop(out_uop), .out_iter_out(out_iter_out),
        .out_iter_in(out_iter_in), .out_dst_factor(out_dst_factor),
        .out_src_factor(out_src_factor), .out_wgt_factor(out_wgt_factor),
        .out_reset(out_reset), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_insn(
        input bit rr, input int bgn, input int en, input int no, input int ni,
        input logic [10:0] dfo, input logic [10:0] dfi,
        input logic [10:0] sfo, input logic [10:0] sfi,
        input logic [9:0] wfo, input logic [9:0] wfi);
        logic [127:0] w;
        w = '0;
        w[6:0]     = 7'($urandom);
        w[127]     = 1'($urandom);
        w[7]       = rr;
        w[20:8]    = 13'(bgn);
        w[34:21]   = 14'(en);
        w[48:35]   = 14'(no);
        w[62:49]   = 14'(ni);
        w[73:63]   = dfo;
        w[84:74]   = dfi;
        w[95:85]   = sfo;
        w[106:96]  = sfi;
        w[116:107] = wfo;
        w[126:117] = wfi;
        return w;
    endfunction

    task automatic run(input bit rr, input int bgn, input int en,
                       input int no, input int ni,
                       input logic [10:0] dfo, input logic [10:0] dfi,
                       input logic [10:0] sfo, input logic [10:0] sfi,
                       input logic [9:0] wfo, input logic [9:0] wfi,
                       input int mode);
        logic [60:0] q[$];
        logic [60:0] e;
        logic [60:0] prev;
        bit          prev_stall;
        int          n, nrd, npop, first_rd, first_ov, last_pop, done_k;
        int          occ, maxocc;
        for (int o = 0; o < no; o++)
            for (int i = 0; i < ni; i++)
                for (int u = bgn; u < en; u++)
                    q.push_back({mem[u % 8192], 14'(o), 14'(i),
                                 (o == no-1) && (i == ni-1) && (u == en-1)});
        n = q.size();
        nrd = 0; npop = 0; first_rd = -1; first_ov = -1;
        last_pop = -1; done_k = -1; maxocc = 0; prev_stall = 0; prev = '0;
        @(negedge clk);
        chk("idle_rdy", insn_ready, 1);
        chk("done_low", done, 0);
        insn = mk_insn(rr, bgn, en, no, ni, dfo, dfi, sfo, sfi, wfo, wfi);
        insn_valid = 1'b1;
        out_ready = (mode == 0);
        for (int k = 1; k < 4000; k++) begin
            @(negedge clk);
            insn_valid = 1'b0;
            insn = '0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (k >= 6 && k <= 10) ? 1'b0 : 1'(k % 2);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            occ = nrd - npop;
            if (occ > maxocc) maxocc = occ;
            if (k == 1 && n > 0) chk("busy_run", busy, 1);
            if (prev_stall)
                chk("hold", {out_valid, out_uop, out_iter_out, out_iter_in,
                             out_last}, {1'b1, prev});
            prev_stall = out_valid && !out_ready;
            prev = {out_uop, out_iter_out, out_iter_in, out_last};
            if (uop_rd_en) begin
                nrd++;
                if (first_rd < 0) first_rd = k;
            end
            if (out_valid && first_ov < 0) first_ov = k;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("beat", {out_uop, out_iter_out, out_iter_in,
                                 out_last}, e);
                    chk("factors", {out_reset, out_dst_factor,
                                    out_src_factor, out_wgt_factor},
                        {rr, dfi, dfo, sfi, sfo, wfi, wfo});
                end
                npop++;
                last_pop = k;
            end
            if (done) begin
                done_k = k;
                chk("done_rdy", insn_ready, 1);
                chk("done_busy", busy, 0);
                break;
            end
        end
        if (done_k < 0) chk("timeout", 0, 1);
        chk("beats", npop, n);
        chk("reads", nrd, n);
        chk("left", q.size(), 0);
        chk("done_cyc", done_k, (n == 0) ? 1 : last_pop + 1);
        chk("maxocc", maxocc <= 2, 1);
        if (mode == 0 && n > 0) begin
            chk("first_rd", first_rd, 1);
            chk("first_ov", first_ov, 2);
            chk("last_at", last_pop, 1 + n);
        end
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        insn = mk_insn(0, 4, 6, 2, 3, 0, 0, 0, 0, 0, 0);
        insn_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        insn_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_ov", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", insn_ready, 1);
        chk("rst_done", done, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rst_quiet", {out_valid, uop_rd_en}, 0);
        end
    endtask

    initial begin
        int bgn, en, no, ni;
        for (int a = 0; a < 8192; a++) mem[a] = $urandom;
        rst = 1'b1;
        insn_valid = 1'b0;
        insn = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", insn_ready, 1);
        chk("rst_ctl", {uop_rd_en, out_valid, out_last, busy, done}, 0);
        chk("rst_data", {out_uop, out_iter_out, out_iter_in, out_reset,
                         out_dst_factor, out_src_factor, out_wgt_factor}, 0);
        rst = 1'b0;

        run(0, 4, 6, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        run(0, 4, 6, 2, 3, 0, 0, 0, 0, 0, 0, 1);
        run(0, 4, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        run(0, 10, 10, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        reset_mid_run();
        run(0, 4, 6, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        run(1, 4, 6, 2, 3, 5, 3, 2, 7, 4, 1, 2);
        run(0, 8190, 8193, 1, 2, 9, 8, 7, 6, 5, 4, 2);
        for (int t = 0; t < 10; t++) begin
            bgn = $urandom_range(0, 8191);
            en  = bgn + $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0 && bgn > 0) en = bgn - 1;
            no = $urandom_range(0, 3);
            ni = $urandom_range(0, 3);
            run(1'($urandom), bgn, en, no, ni,
                11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom),
                10'($urandom), 10'($urandom), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm_loop_ctrl.md
# gemm_loop_ctrl

GEMM loop sequencer: accepts one 128-bit GEMM instruction and walks its two-level loop nest over the micro-op range. For every (iter_out, iter_in, uop) triple it fetches the micro-op from uop SRAM and emits one beat carrying the uop, the current loop indices and the dst/src/wgt factors. The beat stream feeds the combinational index calculator and the GEMM datapath. Dependency-token fields are handled upstream and ignored here.

## Interface
Parameters:
- UOP_AW, 13, uop SRAM address width (matches uop_bgn)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- insn_valid  in  1  instruction offered
- insn_ready  out  1  high only in IDLE
- insn  in  128  GEMM instruction (fields below)
- uop_rd_en  out  1  SRAM read strobe; data valid exactly 1 cycle later
- uop_rd_addr  out  UOP_AW  SRAM address
- uop_rd_data  in  32  micro-op {wgt[31:22], inp[21:11], acc[10:0]}
- out_valid / out_ready  out / in  1  beat handshake
- out_uop  out  32  fetched micro-op
- out_iter_out, out_iter_in  out  14  current loop indices
- out_dst_factor, out_src_factor  out  22  {in[21:11], out[10:0]}
- out_wgt_factor  out  20  {in[19:10], out[9:0]}
- out_reset  out  1  insn[7], constant for the whole instruction
- out_last  out  1  final beat of the instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at instruction completion

Instruction fields: reset_reg [7], uop_bgn [20:8], uop_end [34:21], iter_out [48:35], iter_in [62:49], dst_factor_out [73:63], dst_factor_in [84:74], src_factor_out [95:85], src_factor_in [106:96], wgt_factor_out [116:107], wgt_factor_in [126:117].

## Operation
- FSM: IDLE -> RUN on insn_valid && insn_ready. Latch all fields, clear counters i_out=0, i_in=0, u=uop_bgn.
- Zero-trip: iter_out==0, iter_in==0 or uop_end<=uop_bgn -> IDLE next cycle with done=1. No reads, no beats.
- Issue order: u is innermost (uop_bgn..uop_end-1), then i_in (0..iter_in-1), then i_out (0..iter_out-1). Each read captures its index and last tag into a pending register.
- u, i_in and i_out advance only on a read issue; on u wrap u reloads uop_bgn.
- Buffering: output register plus one skid entry.
  - occ = out_valid + skid_valid + rd_pend.
  - Issue a read iff reads remain and occ - (out_valid && out_ready) < 2.
  - Returning data fills the output register if it is empty or being drained, else the skid entry.
  - Order is strictly preserved.
- Counter width: u counts in 14 bits. uop_rd_addr = u[12:0].
- After the out_last beat handshakes: IDLE next cycle, done=1, insn_ready=1 that same cycle.
- rst at any time: state=IDLE, all valids, rd_pend and counters cleared. In-flight read data is discarded.

## Timing
- Reset values: insn_ready=1; uop_rd_en=0, out_valid=0, out_last=0, busy=0, done=0; all data outputs 0.
- Insn accepted at cycle t: first uop_rd_en at t+1, first out_valid at t+2.
- With out_ready held high: one beat per cycle, no bubbles.
- Total beats = iter_out*iter_in*(uop_end-uop_bgn). Last beat accepted at t+1+N.
- Outputs hold stable while out_valid && !out_ready.

## Structure
- Shared package/header: insn field bit positions, uop field positions, FSM state encodings.
- One sub-module, gemm_loop_skid: 2-entry order-preserving holding buffer with occupancy output.
- Index arithmetic stays outside this block.

## Test plan
- uop_bgn=4, uop_end=6, iter_out=2, iter_in=3, out_ready=1: 12 beats. Addresses 4,5,4,5,…; (i_out,i_in) go (0,0),(0,0),(0,1)…(1,2); out_last only on beat 12; done at cycle t+14.
- Same insn, out_ready toggling 1/0 plus a 5-cycle stall: no beat lost or duplicated. Skid never overflows; at most 2 reads outstanding+buffered.
- iter_in=0: accepted, zero uop_rd_en, done pulse at t+1, insn_ready high at t+1.
- uop_bgn=10, uop_end=10: zero-trip, same response as above.
- rst asserted mid-run with 1 read in flight and skid full: next cycle out_valid=0, busy=0, insn_ready=1. Late SRAM data is not emitted. New insn then runs correctly.
- reset_reg=1, factors dst={3,5}, src={7,2}, wgt={1,4}: every beat carries out_reset=1 and the exact factor values.
